// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags.
// Ports: rs1/rs2 reads with commit bypass, cmd rename, ROB commit, rollback.
module reg_file #(
  parameter int REG_NUM       = 32,
  parameter int REG_POS_WIDTH = 5,
  parameter int ROB_ID_WIDTH  = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [REG_POS_WIDTH-1:0] rs1_from_cmd,
  input  logic [REG_POS_WIDTH-1:0] rs2_from_cmd,
  output logic [ROB_ID_WIDTH-1:0]  Q1_to_cmd,
  output logic [ROB_ID_WIDTH-1:0]  Q2_to_cmd,
  output logic [DATA_WIDTH-1:0]    V1_to_cmd,
  output logic [DATA_WIDTH-1:0]    V2_to_cmd,
  input  logic                     enable_sign_from_cmd,
  input  logic [REG_POS_WIDTH-1:0] rd_from_cmd,
  input  logic [ROB_ID_WIDTH-1:0]  rob_id_from_cmd,
  input  logic                     commit_sign_from_rob,
  input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
  input  logic [DATA_WIDTH-1:0]    V_from_rob,
  input  logic                     rollback_sign
);

  logic [DATA_WIDTH-1:0]   value [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag   [REG_NUM];

  logic hit1;
  logic hit2;
  logic cmt_ok;
  logic ren_ok;

  assign cmt_ok = commit_sign_from_rob
               && (rd_from_rob != '0);
  assign ren_ok = enable_sign_from_cmd
               && (rd_from_cmd != '0)
               && !rollback_sign;

  // Bypass only when the committing entry
  // is still the register's live producer.
  assign hit1 = commit_sign_from_rob
             && (rs1_from_cmd != '0)
             && (rd_from_rob == rs1_from_cmd)
             && (tag[rs1_from_cmd] == Q_from_rob);
  assign hit2 = commit_sign_from_rob
             && (rs2_from_cmd != '0)
             && (rd_from_rob == rs2_from_cmd)
             && (tag[rs2_from_cmd] == Q_from_rob);

  always_comb begin
    Q1_to_cmd = tag[rs1_from_cmd];
    V1_to_cmd = value[rs1_from_cmd];
    unique case (1'b1)
      (rs1_from_cmd == '0): begin
        Q1_to_cmd = '0;
        V1_to_cmd = '0;
      end
      hit1: begin
        Q1_to_cmd = '0;
        V1_to_cmd = V_from_rob;
      end
      default: ;
    endcase
  end

  always_comb begin
    Q2_to_cmd = tag[rs2_from_cmd];
    V2_to_cmd = value[rs2_from_cmd];
    unique case (1'b1)
      (rs2_from_cmd == '0): begin
        Q2_to_cmd = '0;
        V2_to_cmd = '0;
      end
      hit2: begin
        Q2_to_cmd = '0;
        V2_to_cmd = V_from_rob;
      end
      default: ;
    endcase
  end

  // Later assignments win: rollback clears
  // everything, rename overrides commit clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (cmt_ok) begin
        value[rd_from_rob] <= V_from_rob;
        if (tag[rd_from_rob] == Q_from_rob)
          tag[rd_from_rob] <= '0;
      end
      if (rollback_sign) begin
        for (int i = 0; i < REG_NUM; i++)
          tag[i] <= '0;
      end else if (ren_ok) begin
        tag[rd_from_cmd] <= rob_id_from_cmd;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Directed scenarios plus randomized traffic vs a reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [3:0]  q1;
  logic [3:0]  q2;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        en = 1'b0;
  logic [4:0]  rd_c = '0;
  logic [3:0]  id_c = '0;
  logic        cm = 1'b0;
  logic [4:0]  rd_r = '0;
  logic [3:0]  q_r = '0;
  logic [31:0] v_r = '0;
  logic        rb = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] mval [32];
  logic [3:0]  mtag [32];

  reg_file dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .rs1_from_cmd         (rs1),
    .rs2_from_cmd         (rs2),
    .Q1_to_cmd            (q1),
    .Q2_to_cmd            (q2),
    .V1_to_cmd            (v1),
    .V2_to_cmd            (v2),
    .enable_sign_from_cmd (en),
    .rd_from_cmd          (rd_c),
    .rob_id_from_cmd      (id_c),
    .commit_sign_from_rob (cm),
    .rd_from_rob          (rd_r),
    .Q_from_rob           (q_r),
    .V_from_rob           (v_r),
    .rollback_sign        (rb)
  );

  always #5 clk = ~clk;

  task automatic check(input string t,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", t, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_q(input logic [4:0] rs);
    if (rs == 0) return 4'd0;
    if (cm && rd_r == rs && mtag[rs] == q_r) return 4'd0;
    return mtag[rs];
  endfunction

  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (cm && rd_r == rs && mtag[rs] == q_r) return v_r;
    return mval[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0;
      mtag[i] = '0;
    end
  endtask

  task automatic idle();
    en = 0; rd_c = 0; id_c = 0;
    cm = 0; rd_r = 0; q_r = 0; v_r = 0;
    rb = 0; rdy = 1;
  endtask

  task automatic rename(input logic [4:0] r,
                        input logic [3:0] id);
    en = 1; rd_c = r; id_c = id;
  endtask

  task automatic commit(input logic [4:0] r,
                        input logic [3:0] q,
                        input logic [31:0] v);
    cm = 1; rd_r = r; q_r = q; v_r = v;
  endtask

  task automatic cmp_reads(input string t);
    #1;
    check({t, "_q1"}, 32'(q1), 32'(exp_q(rs1)));
    check({t, "_v1"}, v1, exp_v(rs1));
    check({t, "_q2"}, 32'(q2), 32'(exp_q(rs2)));
    check({t, "_v2"}, v2, exp_v(rs2));
  endtask

  task automatic tick();
    logic [3:0] nt [32];
    @(posedge clk);
    if (rst && rdy) begin
      nt = mtag;
      if (cm && rd_r != 0) begin
        mval[rd_r] = v_r;
        if (mtag[rd_r] == q_r) nt[rd_r] = 0;
      end
      if (rb) begin
        for (int i = 0; i < 32; i++) nt[i] = 0;
      end else if (en && rd_c != 0) begin
        nt[rd_c] = id_c;
      end
      mtag = nt;
    end
    #1;
  endtask

  initial begin
    model_clear();
    idle();
    rs1 = 5; rs2 = 7;
    #3;
    check("rst_q1", 32'(q1), 0);
    check("rst_v1", v1, 0);
    @(posedge clk); #1;
    rst = 1;

    // rename then commit with bypass
    rename(5, 3);
    tick(); idle();
    rs1 = 5; #1;
    check("ren_q1", 32'(q1), 3);
    commit(5, 3, 32'hDEADBEEF);
    #1;
    check("byp_q1", 32'(q1), 0);
    check("byp_v1", v1, 32'hDEADBEEF);
    tick(); idle(); #1;
    check("cmt_q1", 32'(q1), 0);
    check("cmt_v1", v1, 32'hDEADBEEF);

    // stale commit keeps newer rename
    rename(7, 2); tick();
    rename(7, 4); tick(); idle();
    rs1 = 7;
    commit(7, 2, 32'h11);
    #1;
    check("stale_q1", 32'(q1), 4);
    check("stale_v1", v1, 0);
    tick(); idle(); #1;
    check("stale2_q1", 32'(q1), 4);
    check("stale2_v1", v1, 32'h11);

    // simultaneous commit and rename
    rename(9, 6); tick(); idle();
    commit(9, 6, 32'h55);
    rename(9, 8);
    tick(); idle();
    rs1 = 9; #1;
    check("sim_q1", 32'(q1), 8);
    check("sim_v1", v1, 32'h55);

    // rollback with commit and rename
    rename(1, 1); tick();
    rename(2, 2); tick(); idle();
    rb = 1;
    commit(1, 1, 32'h40);
    rename(3, 5);
    tick(); idle();
    rs1 = 1; rs2 = 2; #1;
    check("rb_q1", 32'(q1), 0);
    check("rb_q2", 32'(q2), 0);
    check("rb_v1", v1, 32'h40);
    rs1 = 3; rs2 = 9; #1;
    check("rb_x3", 32'(q1), 0);
    check("rb_x9", 32'(q2), 0);

    // x0 is never written
    rename(0, 7);
    commit(0, 0, 32'hFF);
    rs1 = 0; rs2 = 0; #1;
    check("x0_q1", 32'(q1), 0);
    check("x0_v1", v1, 0);
    tick(); idle(); #1;
    check("x0_q2", 32'(q2), 0);
    check("x0_v2", v2, 0);

    // rdy low freezes state
    rename(4, 9); tick(); idle();
    rdy = 0;
    commit(4, 9, 32'h77);
    rename(6, 2);
    tick(); idle();
    rs1 = 4; rs2 = 6; #1;
    check("rdy_q1", 32'(q1), 9);
    check("rdy_v1", v1, 0);
    check("rdy_q2", 32'(q2), 0);

    // mid-run async reset
    rs1 = 4; rs2 = 5;
    rst = 0; #1;
    model_clear();
    check("mrst_q1", 32'(q1), 0);
    check("mrst_v2", v2, 0);
    tick();
    rst = 1;
    #1;
    check("mrst_q1b", 32'(q1), 0);
    check("mrst_v1b", v1, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      rdy  = ($urandom_range(0, 9) != 0);
      rb   = ($urandom_range(0, 29) == 0);
      en   = ($urandom_range(0, 1) == 1);
      rd_c = 5'($urandom_range(0, 7));
      id_c = 4'($urandom_range(1, 15));
      cm   = ($urandom_range(0, 1) == 1);
      rd_r = 5'($urandom_range(0, 7));
      q_r  = ($urandom_range(0, 2) != 0) ?
             mtag[rd_r] : 4'($urandom_range(1, 15));
      v_r  = $urandom;
      cmp_reads("rnd");
      tick();
    end
    idle();
    for (int r = 1; r < 8; r++) begin
      rs1 = 5'(r); rs2 = 5'(r);
      cmp_reads("fin");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port and upstream of the commander's operand fetch.
- At dispatch, the commander reads the value and ROB tag of rs1/rs2, then renames rd to the newly allocated ROB id.
- At commit, the ROB writes the result back and the matching tag is released.
- Rollback discards all speculative tags.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
- REG_POS_WIDTH, 5, register index width
- ROB_ID_WIDTH, 4, ROB id width; id 0 = INVALID_ROB (no producer), valid ids 1..2^ROB_ID_WIDTH-1
- DATA_WIDTH, 32, register data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; when low, all state holds
- rs1_from_cmd  in  REG_POS_WIDTH  source 1 index
- rs2_from_cmd  in  REG_POS_WIDTH  source 2 index
- Q1_to_cmd  out  ROB_ID_WIDTH  producer tag of rs1 (0 = value valid)
- Q2_to_cmd  out  ROB_ID_WIDTH  producer tag of rs2
- V1_to_cmd  out  DATA_WIDTH  value of rs1
- V2_to_cmd  out  DATA_WIDTH  value of rs2
- enable_sign_from_cmd  in  1  dispatch: rename rd this cycle
- rd_from_cmd  in  REG_POS_WIDTH  destination being renamed
- rob_id_from_cmd  in  ROB_ID_WIDTH  ROB id allocated to rd
- commit_sign_from_rob  in  1  commit valid
- rd_from_rob  in  REG_POS_WIDTH  committed destination
- Q_from_rob  in  ROB_ID_WIDTH  ROB id of committing entry
- V_from_rob  in  DATA_WIDTH  committed value
- rollback_sign  in  1  flush all speculative state

Behaviour:
- State: value[0..REG_NUM-1], tag[0..REG_NUM-1]. Reset (rst=0, async) clears both arrays to 0. Read outputs are therefore 0 during and after reset.
- Reads are combinational with commit bypass (per port, shown for rs1):
  - rs1==0 -> Q1=0, V1=0.
  - If commit_sign_from_rob && rd_from_rob==rs1 && tag[rs1]==Q_from_rob -> Q1=0, V1=V_from_rob.
  - Otherwise Q1=tag[rs1], V1=value[rs1].
  - Reads never observe a same-cycle rename. An instruction whose rs equals its own rd therefore gets the old producer.
- Sequential update on rising clk, only when rst=1 and rdy=1; rdy=0 freezes everything.
- Commit (commit_sign_from_rob && rd_from_rob!=0):
  - value[rd_from_rob] <= V_from_rob, always, regardless of tag.
  - tag[rd_from_rob] <= 0 only if tag==Q_from_rob. A newer rename is kept.
- Rename (enable_sign_from_cmd && rd_from_cmd!=0 && !rollback_sign): tag[rd_from_cmd] <= rob_id_from_cmd.
- Commit and rename to the same register in the same cycle: the value is written and the rename wins (tag = rob_id_from_cmd).
- rollback_sign=1: all tags <= 0 and any rename is ignored. A commit in the same cycle (the mispredicted branch, e.g. jal rd) still writes its value.
- Writes or renames to x0 are ignored; value[0] and tag[0] stay 0.
- No output registers; latency is 0 for reads and 1 cycle for state visibility.

Test Plan:
- Reset: assert rst=0 mid-run with tags set, release -> all Q*/V* read 0; tag of x5 = 0.
- Rename then commit: dispatch rd=5, rob_id=3; next cycle rs1=5 -> Q1=3. Commit rd=5, Q=3, V=0xDEADBEEF -> same cycle Q1=0, V1=0xDEADBEEF (bypass); next cycle tag[5]=0, value=0xDEADBEEF.
- Stale commit: rename x7->2, then x7->4; commit rd=7, Q=2, V=0x11 -> value[7]=0x11, Q of x7 stays 4, no bypass (V1 reads value[7]).
- Simultaneous commit+rename to x9: tag 6 commits V=0x55 while dispatch renames x9->8 -> value[9]=0x55, tag[9]=8.
- Rollback: tags x1=1, x2=2; rollback_sign with commit rd=1, Q=1, V=0x40 and rename x3->5 -> all tags 0, value[1]=0x40, x3 tag 0.
- x0 and rdy: rename/commit x0 with V=0xFF -> reads 0/0. With rdy=0, a commit to x4 has no effect on the next cycle's state.
